// File: rtl/dlx_sram_ctrl.sv
// DLX data-memory controller: each 32-bit CPU access becomes two wait-stated
// half-word cycles on a 16-bit asynchronous SRAM. Optional store buffer: DLX_SRAM_BYPASS_EN.
module dlx_sram_ctrl #(
    parameter int unsigned WAIT_CYCLES = 2,
    parameter int unsigned ADDR_W      = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       cpu_addr,
    input  logic [31:0]       cpu_wdata,
    input  logic              cpu_we,
    input  logic              cpu_re,
    output logic [31:0]       cpu_rdata,
    output logic              cpu_busy,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_dq_o,
    output logic              mem_dq_oe,
    input  logic [15:0]       mem_dq_i,
    output logic              mem_ce_n,
    output logic              mem_oe_n,
    output logic              mem_we_n
);
    localparam int unsigned IDX_W    = ADDR_W - 1;
    localparam logic [3:0]  CNT_LOAD = 4'(WAIT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LO,
        S_GAP,
        S_HI,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              write_q, write_d;
    logic [15:0]       rlo_q, rlo_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              ce_n_q, ce_n_d;
    logic              oe_n_q, oe_n_d;
    logic              we_n_q, we_n_d;
    logic              dq_oe_q, dq_oe_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       dq_o_q, dq_o_d;

    logic              req;
    logic              req_write;
    logic [IDX_W-1:0]  req_idx;
    logic              bypass_hit;
    logic [31:0]       buf_rdata;
    logic              phase_end;
    logic              in_phase_d;
    logic              cur_write;
    logic [IDX_W-1:0]  cur_idx;
    logic [31:0]       cur_wdata;
    logic              unused_addr_bits;

    assign req              = cpu_re | cpu_we;
    assign req_write        = cpu_we & ~cpu_re;
    assign req_idx          = cpu_addr[ADDR_W:2];
    assign phase_end        = (cnt_q == 4'd0);
    assign unused_addr_bits = ^{cpu_addr[31:ADDR_W+1], cpu_addr[1:0]};

    // While accepting, the outputs launched at the acceptance edge must use the live request
    assign cur_write = (state_q == S_IDLE) ? req_write : write_q;
    assign cur_idx   = (state_q == S_IDLE) ? req_idx   : idx_q;
    assign cur_wdata = (state_q == S_IDLE) ? cpu_wdata : wdata_q;

`ifdef DLX_SRAM_BYPASS_EN
    logic             buf_valid_q;
    logic [IDX_W-1:0] buf_idx_q;
    logic [31:0]      buf_data_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            buf_valid_q <= 1'b0;
            buf_idx_q   <= '0;
            buf_data_q  <= '0;
        end else if (state_q == S_DONE && write_q) begin
            buf_valid_q <= 1'b1;
            buf_idx_q   <= idx_q;
            buf_data_q  <= wdata_q;
        end
    end

    assign bypass_hit = buf_valid_q & cpu_re & (buf_idx_q == req_idx);
    assign buf_rdata  = buf_data_q;
`else
    assign bypass_hit = 1'b0;
    assign buf_rdata  = 32'd0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            idx_q   <= '0;
            wdata_q <= 32'd0;
            write_q <= 1'b0;
            rlo_q   <= 16'd0;
            rdata_q <= 32'd0;
            ce_n_q  <= 1'b1;
            oe_n_q  <= 1'b1;
            we_n_q  <= 1'b1;
            dq_oe_q <= 1'b0;
            addr_q  <= '0;
            dq_o_q  <= 16'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            write_q <= write_d;
            rlo_q   <= rlo_d;
            rdata_q <= rdata_d;
            ce_n_q  <= ce_n_d;
            oe_n_q  <= oe_n_d;
            we_n_q  <= we_n_d;
            dq_oe_q <= dq_oe_d;
            addr_q  <= addr_d;
            dq_o_q  <= dq_o_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (req) state_d = bypass_hit ? S_DONE : S_LO;
            S_LO:    if (phase_end) state_d = S_GAP;
            S_GAP:   state_d = S_HI;
            S_HI:    if (phase_end) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        idx_d   = idx_q;
        wdata_d = wdata_q;
        write_d = write_q;
        if (state_q == S_IDLE && req) begin
            idx_d   = req_idx;
            wdata_d = cpu_wdata;
            write_d = req_write;
        end

        cnt_d = cnt_q;
        if ((state_d == S_LO || state_d == S_HI) && state_d != state_q)
            cnt_d = CNT_LOAD;
        else if (state_q == S_LO || state_q == S_HI)
            cnt_d = cnt_q - 4'd1;

        // Read data is sampled on the last edge of each phase, while OE is still low
        rlo_d   = rlo_q;
        rdata_d = rdata_q;
        if (state_q == S_LO && phase_end && !write_q)
            rlo_d = mem_dq_i;
        if (state_q == S_HI && phase_end && !write_q)
            rdata_d = {mem_dq_i, rlo_q};
        if (state_q == S_IDLE && bypass_hit)
            rdata_d = buf_rdata;
    end

    always_comb begin
        in_phase_d = (state_d == S_LO) || (state_d == S_HI);
        ce_n_d     = ~in_phase_d;
        oe_n_d     = ~(in_phase_d & ~cur_write);
        dq_oe_d    = in_phase_d & cur_write;
        // First cycle of a write phase is address setup, so WE waits one cycle
        we_n_d     = ~(in_phase_d & cur_write & (state_d == state_q));
        addr_d     = addr_q;
        dq_o_d     = dq_o_q;
        if (in_phase_d) begin
            addr_d = {cur_idx, (state_d == S_HI)};
            if (cur_write)
                dq_o_d = (state_d == S_HI) ? cur_wdata[31:16] : cur_wdata[15:0];
        end
    end

    assign cpu_busy  = rst & (((state_q == S_IDLE) & req) |
                              (state_q == S_LO) | (state_q == S_GAP) | (state_q == S_HI));
    assign cpu_rdata = rdata_q;
    assign mem_addr  = addr_q;
    assign mem_dq_o  = dq_o_q;
    assign mem_dq_oe = dq_oe_q;
    assign mem_ce_n  = ce_n_q;
    assign mem_oe_n  = oe_n_q;
    assign mem_we_n  = we_n_q;

endmodule

// File: tb/tb_dlx_sram_ctrl.sv
// Directed bench for dlx_sram_ctrl at WAIT_CYCLES=2 with a behavioural 16-bit SRAM.
// Expectations follow the published cycle timeline; store-buffer cases track DLX_SRAM_BYPASS_EN.
module tb_dlx_sram_ctrl;
`ifdef DLX_SRAM_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] cpu_addr = '0;
    logic [31:0] cpu_wdata = '0;
    logic        cpu_we = 1'b0;
    logic        cpu_re = 1'b0;
    logic [31:0] cpu_rdata;
    logic        cpu_busy;
    logic [19:0] mem_addr;
    logic [15:0] mem_dq_o;
    logic        mem_dq_oe;
    logic [15:0] mem_dq_i;
    logic        mem_ce_n, mem_oe_n, mem_we_n;

    logic [15:0] sram [0:255];
    logic        sram_clr = 1'b1;
    logic [15:0] junk_dq = 16'hA5C3;

    int checks = 0;
    int errors = 0;

    bit          buf_v = 1'b0;
    logic [18:0] buf_idx = '0;

    always #5 clk = ~clk;

    dlx_sram_ctrl #(.WAIT_CYCLES(2), .ADDR_W(20)) dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_we    (cpu_we),
        .cpu_re    (cpu_re),
        .cpu_rdata (cpu_rdata),
        .cpu_busy  (cpu_busy),
        .mem_addr  (mem_addr),
        .mem_dq_o  (mem_dq_o),
        .mem_dq_oe (mem_dq_oe),
        .mem_dq_i  (mem_dq_i),
        .mem_ce_n  (mem_ce_n),
        .mem_oe_n  (mem_oe_n),
        .mem_we_n  (mem_we_n)
    );

    // SRAM latches data when WE rises at the end of a strobed cycle
    always @(posedge clk) begin
        if (sram_clr) begin
            for (int i = 0; i < 256; i++) sram[i] <= 16'h0000;
        end else if (!mem_ce_n && !mem_we_n) begin
            sram[mem_addr[7:0]] <= mem_dq_o;
        end
    end

    assign mem_dq_i = (!mem_ce_n && !mem_oe_n) ? sram[mem_addr[7:0]] : junk_dq;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    // Runs one CPU access starting at the current IDLE cycle; returns in the IDLE cycle after DONE.
    task automatic do_access(input string name, input bit we, input bit re,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [31:0] exp_rdata);
        bit          wr;
        bit          rd;
        bit          hit;
        int          ncyc;
        logic [18:0] idx;
        bit          in_ph, first, half, busy_e;
        wr   = we & ~re;
        rd   = re;
        idx  = addr[20:2];
        hit  = BYP && rd && buf_v && (buf_idx == idx);
        ncyc = hit ? 2 : 7;
        cpu_we = we; cpu_re = re; cpu_addr = addr; cpu_wdata = wdata;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            if (hit) begin
                check($sformatf("%s c%0d busy", name, c), 32'(cpu_busy), 32'(c == 0));
                check($sformatf("%s c%0d ce_n", name, c), 32'(mem_ce_n), 32'd1);
                check($sformatf("%s c%0d oe_n", name, c), 32'(mem_oe_n), 32'd1);
            end else begin
                in_ph  = (c == 1) || (c == 2) || (c == 4) || (c == 5);
                first  = (c == 1) || (c == 4);
                half   = (c >= 4);
                busy_e = (c <= 5);
                check($sformatf("%s c%0d busy", name, c), 32'(cpu_busy), 32'(busy_e));
                check($sformatf("%s c%0d ce_n", name, c), 32'(mem_ce_n), 32'(!in_ph));
                check($sformatf("%s c%0d oe_n", name, c), 32'(mem_oe_n), 32'(!(in_ph && rd)));
                check($sformatf("%s c%0d we_n", name, c), 32'(mem_we_n), 32'(!(in_ph && wr && !first)));
                check($sformatf("%s c%0d dq_oe", name, c), 32'(mem_dq_oe), 32'(in_ph && wr));
                if (in_ph)
                    check($sformatf("%s c%0d addr", name, c), 32'(mem_addr), 32'({idx, half}));
                if (in_ph && wr)
                    check($sformatf("%s c%0d dq_o", name, c), 32'(mem_dq_o),
                          half ? 32'(wdata[31:16]) : 32'(wdata[15:0]));
            end
            if (c == ncyc - 1 && rd)
                check($sformatf("%s done rdata", name), cpu_rdata, exp_rdata);
            @(posedge clk); #1;
        end
        cpu_we = 1'b0; cpu_re = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        if (wr) begin
            buf_v   = 1'b1;
            buf_idx = idx;
        end
        $display("txn %s we=%0b re=%0b addr=%08h wdata=%08h rdata=%08h cycles=%0d",
                 name, we, re, addr, wdata, cpu_rdata, ncyc);
    endtask

    initial begin
        // Reset with random inputs
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            cpu_addr = $urandom; cpu_wdata = $urandom;
            cpu_we = 1'($urandom); cpu_re = 1'($urandom); junk_dq = 16'($urandom);
            if (i == 3) begin cpu_we = 1'b1; cpu_re = 1'b1; end
            @(negedge clk);
            check("rst ce_n", 32'(mem_ce_n), 32'd1);
            check("rst oe_n", 32'(mem_oe_n), 32'd1);
            check("rst we_n", 32'(mem_we_n), 32'd1);
            check("rst dq_oe", 32'(mem_dq_oe), 32'd0);
            check("rst busy", 32'(cpu_busy), 32'd0);
            check("rst rdata", cpu_rdata, 32'd0);
            check("rst addr", 32'(mem_addr), 32'd0);
            check("rst dq_o", 32'(mem_dq_o), 32'd0);
        end
        $display("txn reset with random inputs");
        cpu_we = 1'b0; cpu_re = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        junk_dq = 16'hA5C3;
        sram_clr = 1'b0;
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;

        do_access("write10", 1'b1, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0);
        check("sram lo after write", 32'(sram[8]), 32'h0000_BEEF);
        check("sram hi after write", 32'(sram[9]), 32'h0000_DEAD);

        do_access("read10", 1'b0, 1'b1, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("rdata hold idle", cpu_rdata, 32'hDEAD_BEEF);
            check("busy idle", 32'(cpu_busy), 32'd0);
            @(posedge clk); #1;
        end

        do_access("both10", 1'b1, 1'b1, 32'h0000_0013, 32'h5555_5555, 32'hDEAD_BEEF);
        check("sram lo after both", 32'(sram[8]), 32'h0000_BEEF);
        check("sram hi after both", 32'(sram[9]), 32'h0000_DEAD);

        // Reset in the first HI cycle of a write: low half lands, high half does not
        cpu_we = 1'b1; cpu_addr = 32'h0000_0010; cpu_wdata = 32'hCAFE_1234;
        repeat (4) begin @(posedge clk); #1; end
        check("midrst ce_n before", 32'(mem_ce_n), 32'd0);
        rst = 1'b0;
        #1;
        check("midrst ce_n", 32'(mem_ce_n), 32'd1);
        check("midrst we_n", 32'(mem_we_n), 32'd1);
        check("midrst dq_oe", 32'(mem_dq_oe), 32'd0);
        check("midrst busy", 32'(cpu_busy), 32'd0);
        check("midrst rdata", cpu_rdata, 32'd0);
        $display("txn reset during write addr=00000010 wdata=cafe1234");
        cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        buf_v = 1'b0;
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        do_access("read10 after rst", 1'b0, 1'b1, 32'h0000_0010, 32'h0, 32'hDEAD_1234);

        do_access("write20", 1'b1, 1'b0, 32'h0000_0020, 32'h1234_5678, 32'h0);
        @(negedge clk);
        check("rdata kept across write", cpu_rdata, 32'hDEAD_1234);
        @(posedge clk); #1;
        do_access("read20", 1'b0, 1'b1, 32'h0000_0022, 32'h0, 32'h1234_5678);
        do_access("read10 again", 1'b0, 1'b1, 32'h0000_0010, 32'h0, 32'hDEAD_1234);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/dlx_sram_ctrl.md
# dlx_sram_ctrl

Data-memory controller sitting directly downstream of the DLX CPU's MEM stage. It takes the CPU's single-cycle word-wide data bus (address, write data, write enable, read enable) and executes each access on an external 16-bit asynchronous SRAM. Each 32-bit word is split into two half-word accesses with programmable wait states. A `cpu_busy` output tells the hazard unit to freeze the pipeline until the word completes.

## Interface
- `WAIT_CYCLES`, default 2: clock cycles per half-word phase; legal range 2..15.
- `ADDR_W`, default 20: external half-word address width.
- `clk`  input  1  system clock; all state changes on its rising edge.
- `rst`  input  1  asynchronous, active-low reset.
- `cpu_addr`  input  32  byte address from EX/MEM; bits [1:0] are ignored.
- `cpu_wdata`  input  32  store data.
- `cpu_we`  input  1  store request, level.
- `cpu_re`  input  1  load request, level.
- `cpu_rdata`  output  32  load result.
- `cpu_busy`  output  1  pipeline stall request.
- `mem_addr`  output  ADDR_W  external half-word address.
- `mem_dq_o`  output  16  write data to pad.
- `mem_dq_oe`  output  1  pad output enable; the top level builds the tristate.
- `mem_dq_i`  input  16  read data from pad.
- `mem_ce_n`, `mem_oe_n`, `mem_we_n`  output  1 each  SRAM strobes, active-low.

## Operation
- **Request decode (IDLE only):** `cpu_re` → read; `cpu_we & ~cpu_re` → write; `cpu_we & cpu_re` → treated as a read; neither → stay in IDLE.
- **Latching:** on acceptance, latch the word index `cpu_addr[ADDR_W:2]`, `cpu_wdata` and the direction. Inputs are ignored after this until DONE.
- **Half-word address:** `mem_addr = {word_index[ADDR_W-2:0], half}`.
  - The low half (bits 15:0) is at `half = 0` and is accessed first.
  - The high half (bits 31:16) is at `half = 1`.
- **States:**
  - IDLE → LO when a request is accepted.
  - LO, lasting `WAIT_CYCLES` cycles → GAP.
  - GAP, lasting 1 cycle, all strobes high → HI.
  - HI, lasting `WAIT_CYCLES` cycles → DONE.
  - DONE, lasting 1 cycle → IDLE.
- **Wait counter:** 4-bit, loaded with `WAIT_CYCLES-1` on entry to LO and to HI, decrements every cycle; the phase ends when it reaches 0.
- **Strobes in LO/HI:**
  - `mem_ce_n` is 0 for the whole phase.
  - Read: `mem_oe_n` is 0 for the whole phase. `mem_dq_i` is captured on the final edge of the phase: into `rdata[15:0]` in LO and `rdata[31:16]` in HI.
  - Write: `mem_dq_oe` is 1 and `mem_dq_o` holds the phase's half for the whole phase. `mem_we_n` is 0 in every phase cycle except the first, which is address setup.
- **Register/strobe behaviour:** all strobes, `mem_addr`, `mem_dq_o` and `mem_dq_oe` are registered; there are no glitches.
- **Busy:** `cpu_busy` = `(state==IDLE & (cpu_re|cpu_we)) | state∈{LO, GAP, HI}`. It is combinational in IDLE so the stall is seen in the same cycle as the request.
- **DONE:** busy is 0. The pipeline advances at the end of DONE, and the returning IDLE cycle sees the next instruction's request.
- **Read result:** `cpu_rdata` updates only at read completion and holds between reads.

## Timing
- A request in cycle 0 (IDLE) produces: LO = cycles 1..W, GAP = W+1, HI = W+2..2W+1, DONE = 2W+2.
- `cpu_busy` is high for cycles 0..2W+1 and low in DONE. `cpu_rdata` is valid from DONE onward.
- For W=2, an access takes 7 cycles and busy is high for 6 of them.
- **Reset (asynchronous, any state including mid-write):**
  - State goes to IDLE.
  - Strobes = 1, `mem_dq_oe` = 0, `mem_addr`, `mem_dq_o` and `cpu_rdata` = 0.
  - `cpu_busy` is forced to 0 while `rst` is low.
  - A partially written word stays partially written; it is not retried.
- **Back-to-back requests:** a new request is accepted no earlier than the IDLE cycle after DONE.

## Configuration
- `DLX_SRAM_BYPASS_EN` defined:
  - Keep a one-entry store buffer (valid bit, word index, data), updated at every write's DONE and invalidated by reset.
  - A read whose word index matches a valid entry goes IDLE → DONE with no strobe activity.
  - In that case busy is high for cycle 0 only, and `cpu_rdata` equals the buffered data in DONE.
- Undefined: no buffer; every read performs the full external access.

## Test plan
- **Reset:** assert `rst` low with random inputs → all strobes 1, `mem_dq_oe`=0, `cpu_busy`=0, `cpu_rdata`=0.
- **Write:** 0xDEADBEEF to 0x00000010, W=2 → `mem_addr`=0x8 with `dq_o`=0xBEEF in cycles 1–2 (`we_n`=0 in cycle 2 only), then 0x9 with 0xDEAD in cycles 4–5 (`we_n`=0 in cycle 5 only); busy is high in cycles 0–5.
- **Read:** SRAM model holds 0xBEEF/0xDEAD, read 0x10 → `oe_n`=0 in cycles 1–2 and 4–5, `cpu_rdata`=0xDEADBEEF in cycle 6 and held afterwards.
- **Both enables:** `cpu_we=cpu_re=1` → read sequence, `mem_dq_oe` stays 0.
- **Reset mid-access:** drop `rst` in cycle 4 of a write → `ce_n`/`we_n` go to 1 immediately. After release, a read of 0x10 starts cleanly in LO and returns the old high half with the new low half.
- **Bypass:** with `DLX_SRAM_BYPASS_EN`, write 0x12345678 to 0x20 then read 0x20 → no `ce_n` activity, busy high for 1 cycle, `rdata`=0x12345678. Without the macro, the same read takes the full 7 cycles.
